// File: rtl/tpu_requant_pipe_if.sv
// Port bundle for tpu_requant_pipe: accumulator-row input, config writes,
// packed int8 result output and the delivered-beat counter.
interface tpu_requant_pipe_if #(
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*ACC_W-1:0]   in_data;

  logic                     cfg_we;
  logic [2:0]               cfg_addr;
  logic [31:0]              cfg_wdata;
  logic                     cfg_ready;

  logic                     out_valid;
  logic                     out_ready;
  logic [8*LANES-1:0]       out_data;
  logic [CNT_W-1:0]         out_count;
  logic                     count_clr;

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_addr, cfg_wdata, out_ready, count_clr,
    output in_ready, cfg_ready, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, cfg_we, cfg_addr, cfg_wdata, out_ready, count_clr,
    input  in_ready, cfg_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/tpu_requant_pipe.sv
// TPU output requantization: bias + pre-shift, saturating rounding doubling high
// multiply, rounding right shift, zero-point and clamp, four int8 lanes per beat.
module tpu_requant_pipe #(
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  tpu_requant_pipe_if.slave bus
);
  typedef logic signed [ACC_W-1:0]   acc_t;
  typedef logic signed [2*ACC_W-1:0] prod_t;
  typedef logic        [ACC_W:0]     wide_t;

  localparam acc_t  ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam acc_t  ACC_MAX   = ~ACC_MIN;
  localparam prod_t NUDGE_POS = prod_t'(1) <<< (ACC_W-2);
  localparam prod_t NUDGE_NEG = prod_t'(1) - NUDGE_POS;
  localparam prod_t TRUNC_ADJ = (prod_t'(1) <<< (ACC_W-1)) - prod_t'(1);

  function automatic acc_t pre_shift(input acc_t acc, input acc_t bias,
                                     input logic signed [5:0] shift);
    acc_t x;
    x = acc + bias;
    if (!shift[5] && shift != 6'sd0) x = x << shift[4:0];
    return x;
  endfunction

  function automatic acc_t srdhm(input acc_t a, input acc_t b);
    prod_t p;
    if (a == ACC_MIN && b == ACC_MIN) return ACC_MAX;
    p = $signed({{ACC_W{a[ACC_W-1]}}, a}) * $signed({{ACC_W{b[ACC_W-1]}}, b});
    p = p + ((p >= 0) ? NUDGE_POS : NUDGE_NEG);
    // Arithmetic shift floors; bias negatives up first so the divide truncates toward zero.
    if (p < 0) p = p + TRUNC_ADJ;
    return acc_t'(p >>> (ACC_W-1));
  endfunction

  function automatic logic [7:0] finish_lane(input acc_t y, input logic [5:0] e,
                                             input logic signed [8:0] off,
                                             input logic signed [7:0] lo,
                                             input logic signed [7:0] hi);
    logic [ACC_W-1:0]    mask;
    logic [ACC_W-1:0]    rem;
    logic [ACC_W-1:0]    thr;
    acc_t                z;
    logic signed [ACC_W:0] w;
    mask = ACC_W'((wide_t'(1) << e) - wide_t'(1));
    rem  = y & mask;
    thr  = (mask >> 1) + ACC_W'(y[ACC_W-1]);
    z    = (y >>> e) + ((rem > thr) ? acc_t'(1) : acc_t'(0));
    w    = $signed({z[ACC_W-1], z}) + $signed({{(ACC_W-8){off[8]}}, off});
    if (w < $signed({{(ACC_W-7){lo[7]}}, lo})) return lo;
    if (w > $signed({{(ACC_W-7){hi[7]}}, hi})) return hi;
    return w[7:0];
  endfunction

  // Configuration
  acc_t               bias_q [LANES];
  acc_t               bias_d [LANES];
  acc_t               mult_q, mult_d;
  logic signed [5:0]  shift_q, shift_d;
  logic signed [8:0]  offset_q, offset_d;
  logic signed [7:0]  act_min_q, act_min_d;
  logic signed [7:0]  act_max_q, act_max_d;

  // Pipeline state
  logic               s1_valid_q, s1_valid_d;
  acc_t               s1_x_q [LANES];
  acc_t               s1_x_d [LANES];
  logic               s2_valid_q, s2_valid_d;
  acc_t               s2_y_q [LANES];
  acc_t               s2_y_d [LANES];
  logic               out_valid_q, out_valid_d;
  logic [8*LANES-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  logic               out_load, s2_load, s1_load, cfg_ready;
  logic [5:0]         down_shift;

  // A stage may load when it is empty or its contents move on this same edge.
  assign out_load   = !out_valid_q || bus.out_ready;
  assign s2_load    = !s2_valid_q || out_load;
  assign s1_load    = !s1_valid_q || s2_load;
  assign cfg_ready  = !(s1_valid_q || s2_valid_q || out_valid_q) && !bus.in_valid;
  assign down_shift = shift_q[5] ? 6'(-shift_q) : 6'd0;

  assign bus.in_ready  = s1_load;
  assign bus.cfg_ready = cfg_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

  always_comb begin
    // NOTE: every _d starts from its held value so no branch below can infer a latch.
    bias_d      = bias_q;
    mult_d      = mult_q;
    shift_d     = shift_q;
    offset_d    = offset_q;
    act_min_d   = act_min_q;
    act_max_d   = act_max_q;
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s2_valid_d  = s2_valid_q;
    s2_y_d      = s2_y_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    if (bus.cfg_we && cfg_ready) begin
      unique case (bus.cfg_addr)
        3'd4:    mult_d  = bus.cfg_wdata;
        3'd5:    shift_d = bus.cfg_wdata[5:0];
        3'd6:    offset_d = bus.cfg_wdata[8:0];
        3'd7: begin
          act_min_d = bus.cfg_wdata[15:8];
          act_max_d = bus.cfg_wdata[7:0];
        end
        default: bias_d[bus.cfg_addr[1:0]] = bus.cfg_wdata;
      endcase
    end

    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        for (int k = 0; k < LANES; k++) begin
          s1_x_d[k] = pre_shift($signed(bus.in_data[LANES*ACC_W-1-ACC_W*k -: ACC_W]),
                                bias_q[k], shift_q);
        end
      end
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int k = 0; k < LANES; k++) s2_y_d[k] = srdhm(s1_x_q[k], mult_q);
      end
    end

    if (out_load) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        for (int k = 0; k < LANES; k++) begin
          out_data_d[8*LANES-1-8*k -: 8] =
            finish_lane(s2_y_q[k], down_shift, offset_q, act_min_q, act_max_q);
        end
      end
    end

    if (bus.count_clr)                    out_count_d = '0;
    else if (out_valid_q && bus.out_ready) out_count_d = out_count_q + 1'b1;
  end

  // NOTE: registers use non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) bias_q[k] <= '0;
      mult_q      <= '0;
      shift_q     <= '0;
      offset_q    <= '0;
      act_min_q   <= -8'sd128;
      act_max_q   <= 8'sd127;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      bias_q      <= bias_d;
      mult_q      <= mult_d;
      shift_q     <= shift_d;
      offset_q    <= offset_d;
      act_min_q   <= act_min_d;
      act_max_q   <= act_max_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  // NOTE: payload registers sit behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    s1_x_q <= s1_x_d;
    s2_y_q <= s2_y_d;
  end
endmodule

// File: tb/tb_tpu_requant_pipe.sv
// Scoreboard bench for tpu_requant_pipe: a behavioural requant model fills an
// expected queue at every accepted row; a negedge monitor pops and compares.
module tb_tpu_requant_pipe;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpu_requant_pipe_if #(.LANES(4), .ACC_W(32), .CNT_W(CNT_W)) bus ();

  tpu_requant_pipe #(.LANES(4), .ACC_W(32), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model configuration
  int m_bias [4];
  int m_mult, m_shift, m_off, m_min, m_max;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) m_bias[k] = 0;
    m_mult = 0; m_shift = 0; m_off = 0; m_min = -128; m_max = 127;
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd4: m_mult = int'(d);
      3'd5: m_shift = int'($signed(d[5:0]));
      3'd6: m_off = int'($signed(d[8:0]));
      3'd7: begin m_min = int'($signed(d[15:8])); m_max = int'($signed(d[7:0])); end
      default: m_bias[a[1:0]] = int'(d);
    endcase
  endfunction

  function automatic logic [7:0] model_lane(input int acc, input int k);
    int x, y, z, e;
    longint p, nudge, mask, rem, thr, w;
    x = acc + m_bias[k];
    if (m_shift > 0) x = x <<< m_shift;
    if (x == int'(32'h8000_0000) && m_mult == int'(32'h8000_0000)) y = 32'h7FFF_FFFF;
    else begin
      p = longint'(x) * longint'(m_mult);
      nudge = (p >= 0) ? (64'sd1 <<< 30) : (64'sd1 - (64'sd1 <<< 30));
      y = int'((p + nudge) / 64'sd2147483648);
    end
    e = (m_shift < 0) ? -m_shift : 0;
    mask = (longint'(1) <<< e) - 1;
    rem = longint'(y) & mask;
    thr = (mask >>> 1) + ((y < 0) ? 1 : 0);
    z = int'((longint'(y) >>> e) + ((rem > thr) ? 1 : 0));
    w = longint'(z) + longint'(m_off);
    if (w < m_min) w = m_min;
    if (w > m_max) w = m_max;
    return w[7:0];
  endfunction

  function automatic logic [31:0] model_row(input logic [127:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[31-8*k -: 8] = model_lane(int'(d[127-32*k -: 32]), k);
    return r;
  endfunction

  // Scoreboard monitor, sampling on the falling edge
  logic [31:0] exp_q [$];
  logic        stall_pending = 1'b0;
  logic [31:0] stall_data;
  logic [31:0] last_out;
  int          beats_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_data", bus.out_data, stall_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("out_data", bus.out_data, exp_q.pop_front());
        last_out = bus.out_data;
        beats_seen++;
      end
      stall_pending = bus.out_valid && !bus.out_ready;
      stall_data    = bus.out_data;
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model_row(bus.in_data));
    end
  end

  // Stimulus tasks: all start and end just after a rising edge
  task automatic send_row(input logic [127:0] d);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d, output logic ok);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    @(negedge clk);
    ok = bus.cfg_ready;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    if (ok) model_write(a, d);
  endtask

  task automatic cfg_idle(input logic [2:0] a, input logic [31:0] d);
    logic ok;
    cfg_write(a, d, ok);
    check("cfg_ready_idle", ok, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin @(posedge clk); #1; n++; end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    bus.count_clr = 1'b1;
    @(posedge clk); #1;
    bus.count_clr = 1'b0;
  endtask

  function automatic logic [127:0] rand_row();
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[127-32*k -: 32] = 32'($signed($urandom_range(0, 4000)) - 2000);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   b0, n;
    model_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.cfg_we = 1'b0; bus.cfg_addr = '0;
    bus.cfg_wdata = '0; bus.out_ready = 1'b1; bus.count_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_out_count", bus.out_count, 16'h0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_cfg_ready", bus.cfg_ready, 1'b1);

    // Basic row and three-cycle latency
    cfg_idle(3'd4, 32'h4000_0000);
    send_row({32'd101, 32'd100, -32'sd100, 32'd0});
    @(negedge clk); check("lat_n1", bus.out_valid, 1'b0);
    @(negedge clk); check("lat_n2", bus.out_valid, 1'b0);
    @(negedge clk); check("lat_n3", bus.out_valid, 1'b1);
    check("basic_const", bus.out_data, 32'h3332_CE00);
    @(posedge clk); #1;
    check("count_one", bus.out_count, 16'd1);

    // Negative shift with rounding and output offset
    cfg_idle(3'd5, 32'h0000_003F);
    cfg_idle(3'd6, 32'h0000_0180);
    send_row({32'd101, 32'd0, 32'd0, 32'd0});
    drain();
    check("rshift_const", last_out, 32'h9A80_8080);

    // Clamping, default then narrowed activation range
    cfg_idle(3'd6, 32'h0);
    cfg_idle(3'd5, 32'h7);
    cfg_idle(3'd4, 32'h7FFF_FFFF);
    send_row({32'd1000, -32'sd1000, 32'd1000, -32'sd1000});
    drain();
    check("clamp_full", last_out, 32'h7F80_7F80);
    cfg_idle(3'd7, 32'h0000_F60A);
    send_row({32'd1000, -32'sd1000, 32'd1000, -32'sd1000});
    drain();
    check("clamp_narrow", last_out, 32'h0AF6_0AF6);
    cfg_idle(3'd7, 32'h0000_807F);

    // Saturating multiply corner
    cfg_idle(3'd5, 32'h0);
    cfg_idle(3'd4, 32'h8000_0000);
    send_row({32'h8000_0000, 32'd0, 32'd0, 32'd0});
    drain();
    check("sat_const", last_out, 32'h7F00_0000);

    // Back-to-back rows under a 1,0,0,1 out_ready pattern
    cfg_idle(3'd0, 32'd10);
    cfg_idle(3'd1, -32'sd20);
    cfg_idle(3'd2, 32'd300);
    cfg_idle(3'd4, 32'h5A3C_1234);
    cfg_idle(3'd5, 32'h0000_003D);
    cfg_idle(3'd6, 32'h0000_0005);
    pulse_clr();
    b0 = beats_seen;
    fork
      begin
        for (int i = 0; i < 8; i++) send_row(rand_row());
      end
      begin
        for (int ph = 0; ph < 40; ph++) begin
          bus.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
          @(posedge clk); #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    check("bp_count", bus.out_count, 16'd8);
    check("bp_beats", beats_seen - b0, 8);

    // Config write while rows are in flight is dropped
    bus.out_ready = 1'b0;
    send_row(rand_row());
    send_row(rand_row());
    cfg_write(3'd4, 32'h1234_5678, ok);
    check("cfg_busy_dropped", ok, 1'b0);
    bus.out_ready = 1'b1;
    drain();
    send_row(rand_row());
    drain();

    // Counter clear wins over a simultaneous delivered beat
    bus.out_ready = 1'b0;
    send_row(rand_row());
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    check("clr_out_valid", bus.out_valid, 1'b1);
    @(posedge clk); #1;
    bus.count_clr = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.count_clr = 1'b0;
    check("clr_wins", bus.out_count, 16'd0);
    check("clr_sb_empty", exp_q.size(), 0);

    // Reset in the middle of a stalled stream
    cfg_idle(3'd5, 32'h3);
    cfg_idle(3'd6, 32'h7);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_row(rand_row());
    check("pre_reset_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_out_count", bus.out_count, 16'd0);
    model_reset();
    bus.out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_idle", bus.out_valid, 1'b0);
    end
    @(posedge clk); #1;
    cfg_idle(3'd4, 32'h4000_0000);
    send_row({32'd101, 32'd100, -32'sd100, 32'd0});
    drain();
    check("post_reset_cfg", last_out, 32'h3332_CE00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/tpu_requant_pipe.md
Name: tpu_requant_pipe

Overview:
- Output stage directly downstream of the TPU C buffer; consumes 128-bit result rows (four int32 accumulators, column 0 in bits [127:96]).
- Applies per-column bias and TFLite-style fixed-point requantization (multiplier + shift), adds the output zero-point and clamps to the activation range.
- Packs the four int8 results into one 32-bit word for the CFU response path.
- 3-stage valid/ready pipeline; throughput 1 row/cycle.

Parameters:
LANES, 4, accumulators per row (fixed at 4; other values unsupported)
ACC_W, 32, accumulator width
CNT_W, 16, width of output beat counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  accumulator row valid
in_ready  out  1  stage 1 can accept
in_data  in  128  lane k at [127-32k -: 32], signed
cfg_we  in  1  config write strobe
cfg_addr  in  3  config register select
cfg_wdata  in  32  config write data
cfg_ready  out  1  config writes accepted this cycle
out_valid  out  1  packed result valid
out_ready  in  1  consumer accepts
out_data  out  32  lane k int8 at [31-8k -: 8]
out_count  out  CNT_W  beats delivered since clear
count_clr  in  1  synchronous clear of out_count

Behaviour:
- Reset (async, rst_n=0): all stage valids 0, out_valid=0, out_data=0, out_count=0, bias0..3=0, multiplier=0, shift=0, out_offset=0, act_min=-128, act_max=127.
- Config map: 0..3 bias lane 0..3 (wdata[31:0]); 4 multiplier (wdata[31:0], signed); 5 shift (wdata[5:0], signed, legal -31..+7); 6 out_offset (wdata[8:0], signed); 7 act range (min=wdata[15:8], max=wdata[7:0], signed int8; min<=max required).
- cfg_ready = no stage valid and in_valid=0. cfg_we with cfg_ready=0 is dropped; registers unchanged.
- Handshake: transfer on valid&&ready at rising edge. Global advance rule per stage: stage k loads when stage k empty or stage k+1 loads (out stage loads when out_valid=0 or out_ready=1). in_ready = S1 empty or S1 advancing. No bubbles under continuous out_ready=1.
- out_data/out_valid held stable while out_valid=1 and out_ready=0.
- S1 (per lane): x = acc + bias[k], 32-bit wrap; if shift>0, x = x << shift, 32-bit wrap.
- S2 SRDHM: if x == multiplier == 0x80000000 then y = 0x7FFFFFFF; else p = x*multiplier (64-bit signed), nudge = p>=0 ? 2^30 : 1-2^30, y = (p+nudge)/2^31 truncated toward zero.
- S3: e = shift<0 ? -shift : 0; mask = 2^e-1; rem = y & mask; thr = (mask>>1) + (y<0); z = (y>>>e) + (rem>thr); w = z + out_offset in 33 bits; clamp to [act_min, act_max]; byte into lane k.
- Latency: row accepted in cycle N appears with out_valid=1 in cycle N+3 when not stalled.
- out_count increments on each out_valid&&out_ready; wraps at 2^CNT_W. count_clr wins over a simultaneous increment (result 0).
- Reset mid-operation: in-flight rows discarded; no partial outputs after deassertion.

Test Plan:
- Single row, bias=0, multiplier=0x40000000, shift=0, offset=0, acc lanes {101,100,-100,0} -> out_data=0x33_32_CE_00 in cycle N+3, out_count=1.
- shift=-1, offset=-128, multiplier=0x40000000, acc lane0=101 -> S2 51, S3 26, final -102 (0x9A); other lanes acc=0 -> -128 (0x80).
- Clamp: multiplier=0x7FFFFFFF, shift=+7, acc=1000 -> 127 (0x7F); acc=-1000 -> -128; act range {-10,10} -> 0x0A / 0xF6.
- Saturation corner: bias=0, acc=0x80000000, multiplier=0x80000000 -> y=0x7FFFFFFF, output 127.
- Backpressure: 8 back-to-back rows, out_ready toggled 1,0,0,1,... -> order preserved, no loss/duplicate, out_data stable while stalled, out_count=8.
- cfg_we during busy pipeline -> write dropped, cfg_ready=0; rst_n pulse mid-stream -> out_valid=0 immediately, config back to reset values; count_clr with simultaneous accept -> out_count=0.
